pwm_gen_multi: RTL

Parametrised N-channel PWM generator sharing one period counter. Each channel has its own duty value, adjusted by debounced increment/decrement buttons, plus a global edge-aligned or center-aligned mode. Duty and period changes are double-buffered and take effect only at a PWM cycle boundary, so outputs stay glitch-free. It replaces the single-channel fixed-period generator in LED/motor drive paths.

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/pwm_btn_debounce.sv | 35 +++
 rtl/pwm_gen_multi.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and saturating helpers for the multi-channel PWM generator.
// The helpers operate on a wide vector; callers zero-extend inputs and truncate results.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  // Wide enough that val+step never wraps for any CW up to 31.
  localparam int SAT_W = 33;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] step,
                                               input logic [SAT_W-1:0] lim);
    logic [SAT_W-1:0] sum;
    sum = val + step;
    return (sum > lim) ? lim : sum;
  endfunction

  function automatic logic [SAT_W-1:0] sat_dec(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] step);
    return (val >= step) ? (val - step) : '0;
  endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, two stages sampled on a shared
// sample_en strobe, and a single-cycle press pulse on the sampled rising edge.
module pwm_btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic stage1;
  logic stage2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stage1 <= 1'b0;
      stage2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sample_en) begin
        stage1 <= sync2;
        stage2 <= stage1;
      end
    end
  end

  // Bounce shorter than the sample interval never reaches stage1, so one press gives one pulse.
  assign press = sample_en & stage1 & ~stage2;

endmodule

// File: rtl/pwm_gen_multi.sv
// N-channel PWM generator with one shared edge/center-aligned period counter.
// Duty, period and mode are double-buffered and only take effect at a cycle boundary.
module pwm_gen_multi
  import pwm_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CW        = 8,
  parameter int DUTY_INIT = 0,
  parameter int DUTY_STEP = 1,
  parameter int DEB_DIV   = 250000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode_center,
  input  logic [CW-1:0]        period,
  input  logic [N_CH-1:0]      duty_inc,
  input  logic [N_CH-1:0]      duty_dec,
  output logic [N_CH-1:0]      pwm_out,
  output logic                 cycle_start,
  output logic [N_CH*CW-1:0]   duty_q
);

  // state    | meaning
  // DIR_UP   | counting up towards period_act (the only state used in edge mode)
  // DIR_DOWN | center mode, counting back down towards 0

  localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  logic [DW-1:0]   div_cnt;
  logic            sample_en;
  logic [N_CH-1:0] inc_ev;
  logic [N_CH-1:0] dec_ev;

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  cnt_dir_e        dir;
  cnt_dir_e        dir_nxt;
  logic            boundary;
  logic [CW-1:0]   period_act;
  pwm_mode_e       mode_act;
  logic [CW-1:0]   sat_lim;

  logic [CW-1:0]   duty_pend     [N_CH];
  logic [CW-1:0]   duty_pend_nxt [N_CH];
  logic [CW-1:0]   duty_act      [N_CH];
  logic [N_CH-1:0] raw;

  // Debounce sample strobe shared by every button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DW'(DEB_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign sample_en = (div_cnt == DW'(DEB_DIV - 1));

  for (genvar g = 0; g < N_CH; g++) begin : g_btn
    pwm_btn_debounce u_inc (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .btn       (duty_inc[g]),
      .press     (inc_ev[g])
    );

    pwm_btn_debounce u_dec (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .btn       (duty_dec[g]),
      .press     (dec_ev[g])
    );
  end

  // 100% is period_act+1, except when that would not fit in CW bits.
  assign sat_lim = (&period_act) ? period_act : (period_act + CW'(1));

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      duty_pend_nxt[i] = duty_pend[i];
      if (inc_ev[i] && !dec_ev[i]) begin
        duty_pend_nxt[i] = CW'(sat_inc(SAT_W'(duty_pend[i]), SAT_W'(DUTY_STEP),
                                       SAT_W'(sat_lim)));
      end else if (dec_ev[i] && !inc_ev[i]) begin
        duty_pend_nxt[i] = CW'(sat_dec(SAT_W'(duty_pend[i]), SAT_W'(DUTY_STEP)));
      end
    end
  end

  // Period counter next state; a cycle ends whenever the counter is about to return to 0.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (mode_act == PWM_EDGE || period_act == '0) begin
      cnt_nxt = (cnt == period_act) ? '0 : (cnt + CW'(1));
      dir_nxt = DIR_UP;
    end else if (dir == DIR_UP) begin
      if (cnt == period_act) begin
        cnt_nxt = cnt - CW'(1);
        dir_nxt = DIR_DOWN;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end else begin
      cnt_nxt = cnt - CW'(1);
    end
    boundary = (cnt_nxt == '0);
    if (boundary) begin
      dir_nxt = DIR_UP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dir         <= DIR_UP;
      period_act  <= '0;
      mode_act    <= PWM_EDGE;
      cycle_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      dir         <= dir_nxt;
      cycle_start <= boundary;
      if (boundary) begin
        period_act <= period;
        mode_act   <= mode_center ? PWM_CENTER : PWM_EDGE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        duty_pend[i] <= CW'(DUTY_INIT);
        duty_act[i]  <= CW'(DUTY_INIT);
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        duty_pend[i] <= duty_pend_nxt[i];
        if (boundary) begin
          duty_act[i] <= duty_pend[i];
        end
      end
    end
  end

  // A duty above period_act compares true for every count, giving a constant 1.
  always_comb begin
    raw = '0;
    for (int i = 0; i < N_CH; i++) begin
      raw[i] = (cnt < duty_act[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= raw;
    end
  end

  always_comb begin
    duty_q = '0;
    for (int i = 0; i < N_CH; i++) begin
      duty_q[i*CW +: CW] = duty_act[i];
    end
  end

endmodule
